// File: rtl/wb_bridge_pkg.sv
// Shared types and default constants for the user-area
// Wishbone-to-native request bridges.
package wb_bridge_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_ACK  = 2'd2
  } state_e;

  localparam logic [3:0]  WSTRB_READ       = 4'b0000;
  localparam logic [31:0] DEF_BASE_ADDR    = 32'h3000_0000;
  localparam logic [31:0] DEF_ADDR_MASK    = 32'hFFF0_0000;
  localparam logic [31:0] DEF_TIMEOUT_DATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/wb_bridge_timeout.sv
// Loadable request watchdog: counts while enabled and flags
// expiry once TIMEOUT cycles have elapsed since the last load.
module wb_bridge_timeout #(
  parameter int TIMEOUT = 16
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_load,
  input  logic i_en,
  output logic o_expire
);

  localparam int TW = $clog2(TIMEOUT);
  localparam logic [TW-1:0] LAST = TW'(TIMEOUT - 1);

  logic [TW-1:0] r_timer;

  // Holds at LAST so the count can never wrap back to zero.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_timer <= '0;
    end else if (i_load) begin
      r_timer <= '0;
    end else if (i_en && !o_expire) begin
      r_timer <= r_timer + 1'b1;
    end
  end

  assign o_expire = (r_timer == LAST);

endmodule

// File: rtl/wb_counter_bridge.sv
// Wishbone classic slave forwarding one transaction at a time
// to the user-area counter, with a timeout watchdog.
module wb_counter_bridge
  import wb_bridge_pkg::*;
#(
  parameter int            DW           = 32,
  parameter logic [DW-1:0] BASE_ADDR    = DW'(DEF_BASE_ADDR),
  parameter logic [DW-1:0] ADDR_MASK    = DW'(DEF_ADDR_MASK),
  parameter int            TIMEOUT      = 16,
  parameter logic [DW-1:0] TIMEOUT_DATA = DW'(DEF_TIMEOUT_DATA)
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_ni,
  input  logic          wbs_cyc_i,
  input  logic          wbs_stb_i,
  input  logic          wbs_we_i,
  input  logic [3:0]    wbs_sel_i,
  input  logic [DW-1:0] wbs_adr_i,
  input  logic [DW-1:0] wbs_dat_i,
  output logic          wbs_ack_o,
  output logic [DW-1:0] wbs_dat_o,
  output logic          valid,
  output logic [3:0]    wstrb,
  output logic [DW-1:0] wdata,
  output logic [DW-1:0] addr,
  input  logic          ready,
  input  logic [DW-1:0] rdata,
  output logic          timeout_flag,
  input  logic          timeout_clr
);

  state_e        r_state;
  state_e        w_state_nx;
  logic          w_hit;
  logic          w_expire;
  logic          w_latch;
  logic          w_ok;
  logic          w_to;
  logic          w_ack;
  logic          r_valid;
  logic [3:0]    r_wstrb;
  logic [DW-1:0] r_wdata;
  logic [DW-1:0] r_addr;
  logic [DW-1:0] r_dat;
  logic          r_flag;

  assign w_hit = wbs_cyc_i & wbs_stb_i &
    ((wbs_adr_i & ADDR_MASK) == (BASE_ADDR & ADDR_MASK));

  wb_bridge_timeout #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .i_clk    (wb_clk_i),
    .i_rst_n  (wb_rst_ni),
    .i_load   (w_latch),
    .i_en     (r_state == S_REQ),
    .o_expire (w_expire)
  );

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  // A master abort wins over a completion seen in the same cycle.
  always_comb begin
    w_state_nx = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_hit) w_state_nx = S_REQ;
      end
      S_REQ: begin
        if (!wbs_cyc_i)
          w_state_nx = S_IDLE;
        else if (ready || w_expire)
          w_state_nx = S_ACK;
      end
      S_ACK:   w_state_nx = S_IDLE;
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    w_latch = 1'b0;
    w_ok    = 1'b0;
    w_to    = 1'b0;
    w_ack   = 1'b0;
    unique case (1'b1)
      (r_state == S_IDLE): w_latch = w_hit;
      (r_state == S_REQ): begin
        w_ok = wbs_cyc_i & ready;
        w_to = wbs_cyc_i & ~ready & w_expire;
      end
      (r_state == S_ACK): w_ack = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) begin
      r_valid <= 1'b0;
      r_wstrb <= WSTRB_READ;
      r_wdata <= '0;
      r_addr  <= '0;
      r_dat   <= '0;
      r_flag  <= 1'b0;
    end else begin
      if (w_latch) begin
        r_addr  <= wbs_adr_i;
        r_wdata <= wbs_dat_i;
        r_wstrb <= wbs_we_i ? wbs_sel_i : WSTRB_READ;
      end
      r_valid <= (w_state_nx == S_REQ);
      if (w_ok)
        r_dat <= rdata;
      else if (w_to)
        r_dat <= TIMEOUT_DATA;
      if (w_to)
        r_flag <= 1'b1;
      else if (timeout_clr)
        r_flag <= 1'b0;
    end
  end

  assign wbs_ack_o    = w_ack;
  assign wbs_dat_o    = r_dat;
  assign valid        = r_valid;
  assign wstrb        = r_wstrb;
  assign wdata        = r_wdata;
  assign addr         = r_addr;
  assign timeout_flag = r_flag;

endmodule

// File: tb/tb_wb_counter_bridge.sv
// Randomised self-checking bench for wb_counter_bridge with a
// stand-in counter and a word-level reference memory.
module tb_wb_counter_bridge;

  localparam int          TMO   = 16;
  localparam logic [31:0] TDATA = 32'hDEAD_BEEF;
  localparam logic [31:0] BASE  = 32'h3000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cyc, stb, we;
  logic [3:0]  sel;
  logic [31:0] adr, dat_i;
  logic        ack;
  logic [31:0] dat_o;
  logic        valid;
  logic [3:0]  wstrb;
  logic [31:0] wdata, addr;
  logic        ready;
  logic [31:0] rdata;
  logic        flag, clr;

  int n_cmp = 0;
  int n_bad = 0;
  logic model_flag = 1'b0;

  // cnt_mem is the counter stand-in; ref_mem is the expectation.
  logic [31:0] cnt_mem [logic [31:0]];
  logic [31:0] ref_mem [logic [31:0]];

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: sim time exceeded");
    $fatal(1);
  end

  wb_counter_bridge dut (
    .wb_clk_i     (clk),
    .wb_rst_ni    (rst_n),
    .wbs_cyc_i    (cyc),
    .wbs_stb_i    (stb),
    .wbs_we_i     (we),
    .wbs_sel_i    (sel),
    .wbs_adr_i    (adr),
    .wbs_dat_i    (dat_i),
    .wbs_ack_o    (ack),
    .wbs_dat_o    (dat_o),
    .valid        (valid),
    .wstrb        (wstrb),
    .wdata        (wdata),
    .addr         (addr),
    .ready        (ready),
    .rdata        (rdata),
    .timeout_flag (flag),
    .timeout_clr  (clr)
  );

  function automatic logic [31:0] merge(
    input logic [31:0] old, input logic [31:0] d,
    input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++)
      if (s[b]) r[b*8 +: 8] = d[b*8 +: 8];
    return r;
  endfunction

  function automatic logic [31:0] cnt_rd(input logic [31:0] a);
    return cnt_mem.exists(a) ? cnt_mem[a] : 32'h0;
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : 32'h0;
  endfunction

  // Master + counter driver; dly<0 means the counter never answers.
  task automatic run_txn(
    input  logic w, input logic [3:0] s,
    input  logic [31:0] a, input logic [31:0] d,
    input  int dly, input int budget,
    output int ack_n, output logic [31:0] ack_d,
    output logic ack_f, output int vcnt, output int first_v,
    output logic [3:0] s_strb, output logic [31:0] s_wd,
    output logic [31:0] s_ad, output logic stable);
    int vk;
    ack_n = -1; ack_d = '0; ack_f = 1'b0;
    vcnt = 0; first_v = -1; vk = 0;
    s_strb = '0; s_wd = '0; s_ad = '0; stable = 1'b1;
    cyc = 1'b1; stb = 1'b1; we = w;
    sel = s; adr = a; dat_i = d;
    for (int n = 1; n <= budget; n++) begin
      @(negedge clk);
      if (ready) begin
        ready = 1'b0;
        if (s_strb != 4'h0)
          cnt_mem[s_ad] = merge(cnt_rd(s_ad), s_wd, s_strb);
      end
      if (ack) begin
        ack_n = n; ack_d = dat_o; ack_f = flag;
        break;
      end
      if (valid) begin
        vk++; vcnt++;
        if (first_v < 0) begin
          first_v = n; s_strb = wstrb;
          s_wd = wdata; s_ad = addr;
        end else if (wstrb !== s_strb || wdata !== s_wd ||
                     addr !== s_ad) begin
          stable = 1'b0;
        end
        if (dly >= 0 && vk == dly + 1) begin
          ready = 1'b1;
          rdata = cnt_rd(addr);
        end
      end
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0; ready = 1'b0;
  endtask

  int          t_ack, t_vc, t_fv;
  logic [31:0] t_d, t_wd, t_ad;
  logic [3:0]  t_strb;
  logic        t_f, t_st;

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({ack, valid, flag, wstrb} !== 7'h0) begin
      n_bad++;
      $display("FAIL rst_ctl: got %0h want 0",
               {ack, valid, flag, wstrb});
    end
    n_cmp++;
    if (dat_o !== 32'h0) begin
      n_bad++; $display("FAIL rst_dat: got %0h want 0", dat_o);
    end
    n_cmp++;
    if (wdata !== 32'h0) begin
      n_bad++; $display("FAIL rst_wdata: got %0h want 0", wdata);
    end
    n_cmp++;
    if (addr !== 32'h0) begin
      n_bad++; $display("FAIL rst_addr: got %0h want 0", addr);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_write_hit();
    run_txn(1'b1, 4'hF, BASE, 32'h0000_1234, 1, 40,
            t_ack, t_d, t_f, t_vc, t_fv, t_strb, t_wd, t_ad, t_st);
    ref_mem[BASE] = 32'h0000_1234;
    n_cmp++;
    if (t_ack !== 3) begin
      n_bad++; $display("FAIL wr_lat: got %0d want 3", t_ack);
    end
    n_cmp++;
    if (t_vc !== 2 || t_fv !== 1) begin
      n_bad++;
      $display("FAIL wr_valid: got %0d/%0d want 2/1", t_vc, t_fv);
    end
    n_cmp++;
    if ({t_strb, t_wd, t_ad} !== {4'hF, 32'h1234, BASE}) begin
      n_bad++;
      $display("FAIL wr_bus: got %h %h %h want f 1234 %h",
               t_strb, t_wd, t_ad, BASE);
    end
    n_cmp++;
    if (t_st !== 1'b1) begin
      n_bad++; $display("FAIL wr_stable: got %b want 1", t_st);
    end
    @(negedge clk);
    run_txn(1'b0, 4'hF, BASE, 32'h0, 1, 40,
            t_ack, t_d, t_f, t_vc, t_fv, t_strb, t_wd, t_ad, t_st);
    n_cmp++;
    if (t_d !== ref_rd(BASE) || t_strb !== 4'h0) begin
      n_bad++;
      $display("FAIL wr_readback: got %h/%h want %h/0",
               t_d, t_strb, ref_rd(BASE));
    end
    @(negedge clk);
  endtask

  task automatic test_read_hit();
    cnt_mem[BASE + 32'h40] = 32'h0000_00A5;
    ref_mem[BASE + 32'h40] = 32'h0000_00A5;
    run_txn(1'b0, 4'h3, BASE + 32'h40, 32'hFFFF_FFFF, 1, 40,
            t_ack, t_d, t_f, t_vc, t_fv, t_strb, t_wd, t_ad, t_st);
    n_cmp++;
    if (t_strb !== 4'h0) begin
      n_bad++; $display("FAIL rd_strb: got %h want 0", t_strb);
    end
    n_cmp++;
    if (t_d !== 32'h0000_00A5 || t_ack !== 3) begin
      n_bad++;
      $display("FAIL rd_data: got %h @%0d want a5 @3", t_d, t_ack);
    end
    @(negedge clk);
  endtask

  task automatic test_miss();
    run_txn(1'b1, 4'hF, 32'h3010_0000, 32'h5555, 1, 50,
            t_ack, t_d, t_f, t_vc, t_fv, t_strb, t_wd, t_ad, t_st);
    n_cmp++;
    if (t_vc !== 0 || t_ack !== -1) begin
      n_bad++;
      $display("FAIL miss: got valid=%0d ack=%0d want 0/-1",
               t_vc, t_ack);
    end
    @(negedge clk);
  endtask

  task automatic test_timeout();
    clr = 1'b1;
    run_txn(1'b0, 4'hF, BASE + 32'h8, 32'h0, -1, 40,
            t_ack, t_d, t_f, t_vc, t_fv, t_strb, t_wd, t_ad, t_st);
    clr = 1'b0;
    n_cmp++;
    if (t_ack - t_fv !== TMO || t_vc !== TMO) begin
      n_bad++;
      $display("FAIL tmo_lat: got %0d/%0d want %0d",
               t_ack - t_fv, t_vc, TMO);
    end
    n_cmp++;
    if (t_d !== TDATA) begin
      n_bad++; $display("FAIL tmo_data: got %h want %h", t_d, TDATA);
    end
    n_cmp++;
    if (t_f !== 1'b1) begin
      n_bad++; $display("FAIL tmo_set_clr: got %b want 1", t_f);
    end
    @(negedge clk);
    n_cmp++;
    if (flag !== 1'b1) begin
      n_bad++; $display("FAIL tmo_sticky: got %b want 1", flag);
    end
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    n_cmp++;
    if (flag !== 1'b0) begin
      n_bad++; $display("FAIL tmo_clr: got %b want 0", flag);
    end
    run_txn(1'b1, 4'hF, BASE + 32'hC, 32'h7777, -1, 40,
            t_ack, t_d, t_f, t_vc, t_fv, t_strb, t_wd, t_ad, t_st);
    n_cmp++;
    if (t_ack !== TMO + 1) begin
      n_bad++;
      $display("FAIL tmo_wr_ack: got %0d want %0d", t_ack, TMO + 1);
    end
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
  endtask

  task automatic test_ready_expiry();
    run_txn(1'b0, 4'hF, BASE + 32'h40, 32'h0, TMO - 1, 40,
            t_ack, t_d, t_f, t_vc, t_fv, t_strb, t_wd, t_ad, t_st);
    n_cmp++;
    if (t_d !== ref_rd(BASE + 32'h40) || t_ack !== TMO + 1) begin
      n_bad++;
      $display("FAIL rdy_exp_data: got %h @%0d want %h @%0d",
               t_d, t_ack, ref_rd(BASE + 32'h40), TMO + 1);
    end
    n_cmp++;
    if (t_f !== 1'b0) begin
      n_bad++; $display("FAIL rdy_exp_flag: got %b want 0", t_f);
    end
    @(negedge clk);
  endtask

  task automatic test_abort();
    int seen, acks;
    seen = 0; acks = 0;
    cyc = 1'b1; stb = 1'b1; we = 1'b1;
    sel = 4'hF; adr = BASE + 32'h10; dat_i = 32'hABCD;
    for (int i = 0; i < 5 && seen == 0; i++) begin
      @(negedge clk);
      if (valid) seen = 1;
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    n_cmp++;
    if (seen !== 1) begin
      n_bad++; $display("FAIL abort_start: got %0d want 1", seen);
    end
    @(negedge clk);
    n_cmp++;
    if (valid !== 1'b0) begin
      n_bad++; $display("FAIL abort_valid: got %b want 0", valid);
    end
    for (int i = 0; i < 20; i++) begin
      if (ack) acks++;
      @(negedge clk);
    end
    n_cmp++;
    if (acks !== 0) begin
      n_bad++; $display("FAIL abort_ack: got %0d want 0", acks);
    end
  endtask

  task automatic test_back_to_back();
    logic gap_v;
    run_txn(1'b1, 4'hF, BASE + 32'h20, 32'h1111_0000, 1, 40,
            t_ack, t_d, t_f, t_vc, t_fv, t_strb, t_wd, t_ad, t_st);
    ref_mem[BASE + 32'h20] = 32'h1111_0000;
    n_cmp++;
    if (t_ack !== 3 || t_vc !== 2) begin
      n_bad++;
      $display("FAIL b2b_first: got %0d/%0d want 3/2", t_ack, t_vc);
    end
    @(negedge clk);
    gap_v = valid;
    run_txn(1'b1, 4'hC, BASE + 32'h24, 32'h2222_3333, 1, 40,
            t_ack, t_d, t_f, t_vc, t_fv, t_strb, t_wd, t_ad, t_st);
    ref_mem[BASE + 32'h24] =
      merge(ref_rd(BASE + 32'h24), 32'h2222_3333, 4'hC);
    n_cmp++;
    if (t_ack !== 3 || t_fv !== 1 || gap_v !== 1'b0) begin
      n_bad++;
      $display("FAIL b2b_second: got %0d/%0d/%b want 3/1/0",
               t_ack, t_fv, gap_v);
    end
    @(negedge clk);
    run_txn(1'b0, 4'hF, BASE + 32'h24, 32'h0, 2, 40,
            t_ack, t_d, t_f, t_vc, t_fv, t_strb, t_wd, t_ad, t_st);
    n_cmp++;
    if (t_d !== ref_rd(BASE + 32'h24)) begin
      n_bad++;
      $display("FAIL b2b_readback: got %h want %h",
               t_d, ref_rd(BASE + 32'h24));
    end
    // Strobe already high during the ack cycle is not sampled there.
    run_txn(1'b0, 4'hF, BASE + 32'h20, 32'h0, 1, 40,
            t_ack, t_d, t_f, t_vc, t_fv, t_strb, t_wd, t_ad, t_st);
    n_cmp++;
    if (t_fv !== 2 || t_ack !== 4 ||
        t_d !== ref_rd(BASE + 32'h20)) begin
      n_bad++;
      $display("FAIL stb_in_ack: got %0d/%0d/%h want 2/4/%h",
               t_fv, t_ack, t_d, ref_rd(BASE + 32'h20));
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int seen, acks;
    seen = 0; acks = 0;
    run_txn(1'b0, 4'hF, BASE, 32'h0, -1, 40,
            t_ack, t_d, t_f, t_vc, t_fv, t_strb, t_wd, t_ad, t_st);
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b1;
    sel = 4'h5; adr = BASE + 32'h30; dat_i = 32'h9999_9999;
    for (int i = 0; i < 5 && seen == 0; i++) begin
      @(negedge clk);
      if (valid) seen = 1;
    end
    rst_n = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({ack, valid, flag, wstrb} !== 7'h0 || dat_o !== 32'h0 ||
        wdata !== 32'h0 || addr !== 32'h0 || seen !== 1) begin
      n_bad++;
      $display("FAIL rst_mid: got %b%b%b %h %h %h %h seen=%0d want 0",
               ack, valid, flag, wstrb, dat_o, wdata, addr, seen);
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_flag = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (ack || valid) acks++;
    end
    n_cmp++;
    if (acks !== 0) begin
      n_bad++; $display("FAIL rst_mid_quiet: got %0d want 0", acks);
    end
  endtask

  task automatic test_random();
    logic        hit, w, tmo;
    logic [3:0]  s;
    logic [31:0] a, d, e_d;
    int          dly, e_ack, e_vc;
    for (int it = 0; it < 40; it++) begin
      hit = ($urandom_range(0, 4) != 0);
      a = BASE + 32'(4 * $urandom_range(0, 7));
      if (!hit) a = a ^ (32'h1 << $urandom_range(20, 31));
      w = $urandom_range(0, 1) == 1;
      s = 4'($urandom);
      d = $urandom;
      case ($urandom_range(0, 5))
        0:       dly = -1;
        1:       dly = $urandom_range(TMO - 2, TMO + 2);
        default: dly = $urandom_range(0, 3);
      endcase
      tmo   = (dly < 0 || dly >= TMO);
      e_ack = tmo ? TMO + 1 : dly + 2;
      e_vc  = tmo ? TMO : dly + 1;
      e_d   = tmo ? TDATA : ref_rd(a);
      run_txn(w, s, a, d, dly, 40,
              t_ack, t_d, t_f, t_vc, t_fv, t_strb, t_wd, t_ad, t_st);
      if (!hit) begin
        n_cmp++;
        if (t_ack !== -1 || t_vc !== 0) begin
          n_bad++;
          $display("FAIL rnd_miss: adr=%h got %0d/%0d want -1/0",
                   a, t_ack, t_vc);
        end
      end else begin
        model_flag = model_flag | tmo;
        if (!tmo && w) ref_mem[a] = merge(ref_rd(a), d, s);
        n_cmp++;
        if (t_ack !== e_ack || t_vc !== e_vc) begin
          n_bad++;
          $display("FAIL rnd_timing: dly=%0d got %0d/%0d want %0d/%0d",
                   dly, t_ack, t_vc, e_ack, e_vc);
        end
        n_cmp++;
        if (t_d !== e_d) begin
          n_bad++;
          $display("FAIL rnd_data: adr=%h got %h want %h",
                   a, t_d, e_d);
        end
        n_cmp++;
        if (t_strb !== (w ? s : 4'h0) || t_ad !== a ||
            t_wd !== d || t_st !== 1'b1) begin
          n_bad++;
          $display("FAIL rnd_bus: got %h %h %h %b want %h %h %h 1",
                   t_strb, t_ad, t_wd, t_st, w ? s : 4'h0, a, d);
        end
        n_cmp++;
        if (t_f !== model_flag) begin
          n_bad++;
          $display("FAIL rnd_flag: got %b want %b", t_f, model_flag);
        end
      end
      if ($urandom_range(0, 2) == 0) begin
        clr = 1'b1;
        model_flag = 1'b0;
      end
      @(negedge clk);
      clr = 1'b0;
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    sel = '0; adr = '0; dat_i = '0;
    ready = 1'b0; rdata = '0; clr = 1'b0;
    test_reset();
    test_write_hit();
    test_read_hit();
    test_miss();
    test_timeout();
    test_ready_expiry();
    test_abort();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
